// File: rtl/sram_arbiter.sv
// sram_arbiter: fixed-priority IF/MEM arbiter sequencing multi-cycle accesses to a single-port SRAM
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic              stall_req
);
  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_we;
  logic       r_mem;
  logic       w_wr;
  logic       w_unused;
  assign w_wr      = mem_req & mem_we;
  assign w_unused  = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};
  assign stall_req = rst & ((mem_req & ~mem_ready) | (if_req & ~if_ready));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_mem      <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      if_rdata   <= 32'd0;
      mem_rdata  <= 32'd0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (r_state)
        IDLE: if (mem_req || if_req) begin
          r_state   <= mem_req ? MEM_ACC : IF_ACC;
          r_mem     <= mem_req;
          r_we      <= w_wr;
          r_cnt     <= 4'(WAIT_CYCLES);
          sram_addr <= mem_req ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          sram_ce_n <= 1'b0;
          sram_oe_n <= w_wr;
          sram_we_n <= ~w_wr;
          sram_be_n <= w_wr ? ~mem_be : 4'h0;
          if (w_wr) sram_wdata <= mem_wdata;
        end
        IF_ACC, MEM_ACC: if (r_cnt != 4'd0) begin
          r_cnt     <= r_cnt - 4'd1;
          // the final access cycle releases we_n so address and data are held past the write
          sram_we_n <= ~(r_we && r_cnt != 4'd1);
        end else begin
          r_state   <= DONE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= 4'hF;
          if_ready  <= ~r_mem;
          mem_ready <= r_mem;
          if (!r_we && r_mem) mem_rdata <= sram_rdata;
          if (!r_we && !r_mem) if_rdata <= sram_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port base SRAM between instruction fetch (IF) and the MEM stage's load/store port.
- Sequences each SRAM access through a small FSM with a parameterised access length, then returns read data and a one-cycle ready pulse.
- Drives the pipeline stall request that holds upstream stages while a load/store owns the SRAM.
- Sits between the IF/MEM stages and the SRAM pins. Complements the decode-stage stall flag raised for LB/LW/SB/SW.

Parameters:
- WAIT_CYCLES, default 1: SRAM access cycles beyond the first; legal range 1..15.
- ADDR_W, default 20: SRAM word-address width; sram_addr = byte address[ADDR_W+1:2].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- if_req  input  1  IF read request; held until if_ready.
- if_addr  input  32  IF byte address.
- if_rdata  output  32  fetched word; registered, valid while if_ready=1.
- if_ready  output  1  one-cycle completion pulse for IF.
- mem_req  input  1  MEM request; held until mem_ready.
- mem_we  input  1  1 = write, 0 = read.
- mem_be  input  4  byte enables for writes (bit i = byte i).
- mem_addr  input  32  MEM byte address.
- mem_wdata  input  32  write data, already byte-lane aligned.
- mem_rdata  output  32  loaded word; registered, valid while mem_ready=1.
- mem_ready  output  1  one-cycle completion pulse for MEM.
- sram_addr  output  ADDR_W  SRAM word address.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data.
- sram_ce_n  output  1  chip enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_we_n  output  1  write enable, active-low.
- sram_be_n  output  4  byte enables, active-low.
- stall_req  output  1  pipeline stall request.

Behaviour:
- States: IDLE, IF_ACC, MEM_ACC, DONE. All SRAM outputs, ready pulses, rdata registers and the owner flag are registered.
- Reset (rst=0, asynchronous, including mid-access):
  - state=IDLE, counter=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_addr=0, sram_wdata=0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - Any in-flight access is abandoned with no ready pulse.
- IDLE:
  - If mem_req=1, go to MEM_ACC. Fixed priority: MEM wins when both requests are high.
  - Else if if_req=1, go to IF_ACC.
  - On grant, latch address, we, be and wdata; set counter=WAIT_CYCLES.
  - SRAM stays deselected while in IDLE.
- IF_ACC / MEM_ACC:
  - Lasts WAIT_CYCLES+1 cycles; counter decrements each cycle.
  - Drives sram_ce_n=0 and sram_addr from the latched address.
  - Read: sram_oe_n=0, sram_we_n=1, sram_be_n=4'b0000.
  - Write: sram_oe_n=1, sram_be_n=~be, sram_wdata=latched wdata. sram_we_n=0 in every access cycle except the last, which gives address/data hold.
  - When counter=0: capture sram_rdata into the owner's rdata register (reads only), then go to DONE.
- DONE:
  - One cycle; the owner's ready=1 and SRAM is deselected.
  - Always returns to IDLE. A requester still holding req during its ready cycle is not re-granted in DONE.
- Latency: request first seen high in IDLE at cycle 0 gives ready at cycle WAIT_CYCLES+2. Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Requests and inputs are sampled only in IDLE.
  - Dropping req mid-access: the access still completes and the ready pulse is issued (ignored).
  - Input changes during an access have no effect.
- The write rdata register of the writing port is not updated on writes.
- stall_req = (mem_req & ~mem_ready) | (if_req & ~if_ready). Combinational; 0 during reset.
- if_ready and mem_ready are never high in the same cycle.

Test Plan:
- IF read, WAIT_CYCLES=1, if_req=1 with if_addr=0x8000_0010 at cycle 0, sram_rdata=0x2408_0001:
  - sram_addr=0x00004 and sram_oe_n=0 in cycles 1-2.
  - if_ready=1 at cycle 3 with if_rdata=0x2408_0001.
  - stall_req=1 in cycles 0-2.
- MEM byte store, mem_we=1, mem_be=4'b0100, mem_addr=0x8000_0102, mem_wdata=0x00AB_0000:
  - sram_addr=0x00040, sram_be_n=4'b1011, sram_wdata=0x00AB_0000.
  - sram_we_n=0 in cycle 1 only.
  - mem_ready at cycle 3; mem_rdata unchanged.
- if_req and mem_req both rise at cycle 0:
  - MEM granted first; mem_ready at cycle 3.
  - IF granted in IDLE at cycle 4; if_ready at cycle 7.
  - stall_req stays 1 through cycle 6.
- WAIT_CYCLES=3 MEM load at 0x8000_0008:
  - sram_ce_n=0 in cycles 1-4.
  - mem_ready at cycle 5 with mem_rdata = the sram_rdata value present at cycle 4.
- rst driven to 0 mid-edge during cycle 2 of a write:
  - sram_we_n=1, sram_ce_n=1, sram_be_n=4'hF immediately.
  - No ready pulse.
  - After rst returns to 1 with requests held, the access restarts from IDLE with full latency.
- if_req dropped at cycle 1 of an IF access:
  - if_ready still pulses at cycle 3.
  - A subsequent mem_req is granted at cycle 4.
